// File: rtl/stream_pkg.sv
// Shared stream-infrastructure types and helpers.
// The FIFO family (sync, async, credit) sizes its occupancy counters with the function below.
package stream_pkg;

    typedef struct packed {
        logic reset_async;
        logic reset_active_low;
    } std_clock_info_t;

    localparam std_clock_info_t STD_CLOCK_SYNC_HIGH = '0;

    function automatic int stream_fifo_count_width(int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stream_intf.sv
// Valid/ready stream bundle.
// A beat transfers on a clock edge where valid and ready are both high.
interface stream_intf #(
    parameter int W = 8
) ();

    logic         valid;
    logic         ready;
    logic [W-1:0] payload;

    modport in  (input valid, input payload, output ready);
    modport out (output valid, output payload, input ready);

endinterface

// File: rtl/std_register.sv
// Enable-gated register with a reset vector.
// Only synchronous active-high reset descriptors are accepted.
module std_register
    import stream_pkg::*;
#(
    parameter std_clock_info_t CLOCK_INFO   = STD_CLOCK_SYNC_HIGH,
    parameter int              W            = 1,
    parameter logic [W-1:0]    RESET_VECTOR = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    if (CLOCK_INFO.reset_async || CLOCK_INFO.reset_active_low) begin : g_bad_clock_info
        $error("std_register: only synchronous active-high reset is supported");
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VECTOR;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/stream_fifo_mem.sv
// FIFO payload storage: one synchronous write port, one asynchronous read port.
// Contents are not reset, so a vendor RAM can be dropped in here later.
module stream_fifo_mem #(
    parameter int  DEPTH = 4,
    parameter type T     = logic,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  T              wdata,
    input  logic [AW-1:0] raddr,
    output T              rdata
);

    T mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo.sv
// Multi-entry first-word-fall-through valid/ready FIFO.
// Both stream_in.ready and stream_out.valid come from the registered count only.
module stream_fifo
    import stream_pkg::*;
#(
    parameter std_clock_info_t CLOCK_INFO = 'b0,
    parameter int              DEPTH      = 4,
    parameter type             T          = logic
) (
    input  logic                                      clk,
    input  logic                                      rst,
    stream_intf.in                                    stream_in,
    stream_intf.out                                   stream_out,
    output logic [stream_fifo_count_width(DEPTH)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = stream_fifo_count_width(DEPTH);

    if (DEPTH < 2) begin : g_bad_depth
        $error("stream_fifo: DEPTH must be at least 2");
    end

    if ($bits(T) != $bits(stream_in.payload) || $bits(T) != $bits(stream_out.payload)) begin : g_bad_width
        $error("stream_fifo: payload type width does not match the stream interfaces");
    end

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr_nxt;
    logic [PW-1:0] rd_ptr_nxt;
    logic [CW-1:0] count_nxt;
    logic          count_en;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    T              wr_data;
    T              rd_data;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    assign stream_in.ready    = !full;
    assign stream_out.valid   = !empty;
    assign stream_out.payload = rd_data;

    assign push    = stream_in.valid && !full;
    assign pop     = !empty && stream_out.ready;
    assign wr_data = stream_in.payload;

    // Explicit wrap compare keeps non-power-of-two depths correct.
    assign wr_ptr_nxt = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
    assign rd_ptr_nxt = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);

    always_comb begin
        count_nxt = count;
        count_en  = push ^ pop;
        if (push && !pop) begin
            count_nxt = count + CW'(1);
        end else if (pop && !push) begin
            count_nxt = count - CW'(1);
        end
    end

    std_register #(
        .CLOCK_INFO  (CLOCK_INFO),
        .W           (PW),
        .RESET_VECTOR('0)
    ) u_wr_ptr (
        .clk(clk),
        .rst(rst),
        .en (push),
        .d  (wr_ptr_nxt),
        .q  (wr_ptr)
    );

    std_register #(
        .CLOCK_INFO  (CLOCK_INFO),
        .W           (PW),
        .RESET_VECTOR('0)
    ) u_rd_ptr (
        .clk(clk),
        .rst(rst),
        .en (pop),
        .d  (rd_ptr_nxt),
        .q  (rd_ptr)
    );

    std_register #(
        .CLOCK_INFO  (CLOCK_INFO),
        .W           (CW),
        .RESET_VECTOR('0)
    ) u_count (
        .clk(clk),
        .rst(rst),
        .en (count_en),
        .d  (count_nxt),
        .q  (count)
    );

    stream_fifo_mem #(
        .DEPTH(DEPTH),
        .T    (T)
    ) u_mem (
        .clk  (clk),
        .we   (push),
        .waddr(wr_ptr),
        .wdata(wr_data),
        .raddr(rd_ptr),
        .rdata(rd_data)
    );

endmodule

// File: tb/tb_stream_fifo.sv
// Bench for stream_fifo: a DEPTH=4 instance for fill/drain/reset scenarios and a
// DEPTH=3 instance for wrap-around under random stalls, with a per-instance scoreboard.
module tb_stream_fifo;

    typedef logic [7:0] byte_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    stream_intf #(.W(8)) a_in  ();
    stream_intf #(.W(8)) a_out ();
    stream_intf #(.W(8)) b_in  ();
    stream_intf #(.W(8)) b_out ();

    logic [2:0] a_count;
    logic [1:0] b_count;

    stream_fifo #(.CLOCK_INFO('b0), .DEPTH(4), .T(byte_t)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .stream_in (a_in),
        .stream_out(a_out),
        .count     (a_count)
    );

    stream_fifo #(.CLOCK_INFO('b0), .DEPTH(3), .T(byte_t)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .stream_in (b_in),
        .stream_out(b_out),
        .count     (b_count)
    );

    int    n_checks = 0;
    int    n_pass   = 0;
    byte_t qa[$];
    byte_t qb[$];

    // Scoreboards sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        byte_t exp_a;
        if (rst) begin
            qa.delete();
        end else begin
            if (a_out.valid && a_out.ready) begin
                n_checks++;
                if (qa.size() == 0) begin
                    $display("FAIL a_pop_order: got %h, expected no beat", a_out.payload);
                end else begin
                    exp_a = qa.pop_front();
                    if (a_out.payload !== exp_a)
                        $display("FAIL a_pop_order: got %h, expected %h", a_out.payload, exp_a);
                    else
                        n_pass++;
                end
            end
            if (a_in.valid && a_in.ready) qa.push_back(a_in.payload);
        end
    end

    always @(negedge clk) begin
        byte_t exp_b;
        if (rst) begin
            qb.delete();
        end else begin
            if (b_out.valid && b_out.ready) begin
                n_checks++;
                if (qb.size() == 0) begin
                    $display("FAIL b_pop_order: got %h, expected no beat", b_out.payload);
                end else begin
                    exp_b = qb.pop_front();
                    if (b_out.payload !== exp_b)
                        $display("FAIL b_pop_order: got %h, expected %h", b_out.payload, exp_b);
                    else
                        n_pass++;
                end
            end
            if (b_in.valid && b_in.ready) qb.push_back(b_in.payload);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if (a_count !== 3'd0) $display("FAIL reset_a_count: got %0d, expected 0", a_count);
        else n_pass++;
        n_checks++;
        if (a_in.ready !== 1'b1) $display("FAIL reset_a_ready: got %b, expected 1", a_in.ready);
        else n_pass++;
        n_checks++;
        if (a_out.valid !== 1'b0) $display("FAIL reset_a_valid: got %b, expected 0", a_out.valid);
        else n_pass++;
        n_checks++;
        if (b_count !== 2'd0) $display("FAIL reset_b_count: got %0d, expected 0", b_count);
        else n_pass++;
        n_checks++;
        if (b_in.ready !== 1'b1) $display("FAIL reset_b_ready: got %b, expected 1", b_in.ready);
        else n_pass++;
        n_checks++;
        if (b_out.valid !== 1'b0) $display("FAIL reset_b_valid: got %b, expected 0", b_out.valid);
        else n_pass++;
    endtask

    task automatic test_latency();
        a_out.ready  = 1'b0;
        a_in.valid   = 1'b1;
        a_in.payload = 8'h5A;
        n_checks++;
        if (a_out.valid !== 1'b0) $display("FAIL latency_no_bypass: got valid %b, expected 0", a_out.valid);
        else n_pass++;
        tick();
        a_in.valid = 1'b0;
        n_checks++;
        if (a_out.valid !== 1'b1 || a_out.payload !== 8'h5A)
            $display("FAIL latency_fwft: got valid %b payload %h, expected 1 5a", a_out.valid, a_out.payload);
        else n_pass++;
        a_out.ready = 1'b1;
        tick();
        a_out.ready = 1'b0;
        n_checks++;
        if (a_count !== 3'd0) $display("FAIL latency_drain: got count %0d, expected 0", a_count);
        else n_pass++;
    endtask

    task automatic test_fill();
        a_out.ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_in.valid   = 1'b1;
            a_in.payload = 8'hA1 + 8'(i);
            tick();
            n_checks++;
            if (a_count !== 3'(i + 1)) $display("FAIL fill_count: got %0d, expected %0d", a_count, i + 1);
            else n_pass++;
        end
        n_checks++;
        if (a_in.ready !== 1'b0) $display("FAIL fill_full_ready: got %b, expected 0", a_in.ready);
        else n_pass++;
        a_in.payload = 8'hA5;
        tick();
        tick();
        n_checks++;
        if (a_count !== 3'd4 || a_in.ready !== 1'b0)
            $display("FAIL fill_hold_a5: got count %0d ready %b, expected 4 0", a_count, a_in.ready);
        else n_pass++;
        n_checks++;
        if (a_out.payload !== 8'hA1) $display("FAIL fill_head_stable: got %h, expected a1", a_out.payload);
        else n_pass++;
    endtask

    task automatic test_drain();
        a_out.ready = 1'b1;
        tick();
        n_checks++;
        if (a_count !== 3'd3 || a_in.ready !== 1'b1)
            $display("FAIL drain_first_pop: got count %0d ready %b, expected 3 1", a_count, a_in.ready);
        else n_pass++;
        tick();
        n_checks++;
        if (a_count !== 3'd3) $display("FAIL drain_a5_accept: got count %0d, expected 3", a_count);
        else n_pass++;
        a_in.valid = 1'b0;
        tick();
        tick();
        tick();
        n_checks++;
        if (a_count !== 3'd0 || a_out.valid !== 1'b0)
            $display("FAIL drain_empty: got count %0d valid %b, expected 0 0", a_count, a_out.valid);
        else n_pass++;
        a_out.ready = 1'b0;
    endtask

    task automatic test_simultaneous();
        a_out.ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a_in.valid   = 1'b1;
            a_in.payload = 8'h10 + 8'(i);
            tick();
        end
        n_checks++;
        if (a_count !== 3'd2) $display("FAIL simul_setup: got count %0d, expected 2", a_count);
        else n_pass++;
        a_in.payload = 8'hB0;
        a_out.ready  = 1'b1;
        tick();
        n_checks++;
        if (a_count !== 3'd2) $display("FAIL simul_count: got count %0d, expected 2", a_count);
        else n_pass++;
        n_checks++;
        if (a_out.payload !== 8'h11) $display("FAIL simul_head: got %h, expected 11", a_out.payload);
        else n_pass++;
        a_in.valid = 1'b0;
        tick();
        tick();
        a_out.ready = 1'b0;
        n_checks++;
        if (a_count !== 3'd0) $display("FAIL simul_drain: got count %0d, expected 0", a_count);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int  sent;
        int  got;
        int  cyc;
        logic pushed;
        logic popped;
        sent       = 0;
        got        = 0;
        cyc        = 0;
        b_in.valid = 1'b0;
        while ((sent < 10 || b_count != 2'd0) && cyc < 500) begin
            if (!b_in.valid && sent < 10 && $urandom_range(0, 3) != 0) begin
                b_in.valid   = 1'b1;
                b_in.payload = 8'(sent);
            end
            b_out.ready = ($urandom_range(0, 2) != 0);
            pushed      = b_in.valid && b_in.ready;
            popped      = b_out.valid && b_out.ready;
            if (popped) begin
                n_checks++;
                if (b_out.payload !== 8'(got)) $display("FAIL wrap_seq: got %0d, expected %0d", b_out.payload, got);
                else n_pass++;
            end
            tick();
            if (pushed) begin
                sent++;
                b_in.valid = 1'b0;
            end
            if (popped) got++;
            n_checks++;
            if (b_count > 2'd3) $display("FAIL wrap_count_bound: got %0d, expected <= 3", b_count);
            else n_pass++;
            cyc++;
        end
        b_in.valid  = 1'b0;
        b_out.ready = 1'b0;
        n_checks++;
        if (got !== 10) $display("FAIL wrap_total: got %0d beats, expected 10 (cycles %0d)", got, cyc);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        a_out.ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_in.valid   = 1'b1;
            a_in.payload = 8'h30 + 8'(i);
            tick();
        end
        n_checks++;
        if (a_count !== 3'd3) $display("FAIL rstmid_setup: got count %0d, expected 3", a_count);
        else n_pass++;
        rst          = 1'b1;
        a_in.payload = 8'h99;
        tick();
        rst        = 1'b0;
        a_in.valid = 1'b0;
        n_checks++;
        if (a_count !== 3'd0 || a_out.valid !== 1'b0 || a_in.ready !== 1'b1)
            $display("FAIL rstmid_flush: got count %0d valid %b ready %b, expected 0 0 1",
                     a_count, a_out.valid, a_in.ready);
        else n_pass++;
        a_in.valid   = 1'b1;
        a_in.payload = 8'hC0;
        tick();
        a_in.valid = 1'b0;
        n_checks++;
        if (a_out.valid !== 1'b1 || a_out.payload !== 8'hC0)
            $display("FAIL rstmid_first: got valid %b payload %h, expected 1 c0", a_out.valid, a_out.payload);
        else n_pass++;
        a_out.ready = 1'b1;
        tick();
        a_out.ready = 1'b0;
        n_checks++;
        if (a_count !== 3'd0) $display("FAIL rstmid_drain: got count %0d, expected 0", a_count);
        else n_pass++;
    endtask

    initial begin
        a_in.valid   = 1'b0;
        a_in.payload = '0;
        a_out.ready  = 1'b0;
        b_in.valid   = 1'b0;
        b_in.payload = '0;
        b_out.ready  = 1'b0;

        test_reset();
        test_latency();
        test_fill();
        test_drain();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        tick();

        n_checks++;
        if (qa.size() != 0) $display("FAIL a_leftover: got %0d beats, expected 0", qa.size());
        else n_pass++;
        n_checks++;
        if (qb.size() != 0) $display("FAIL b_leftover: got %0d beats, expected 0", qb.size());
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
